fu_issue_fifo: RTL

FU_ISSUE_FIFO -- requirements
Module: fu_issue_fifo

---
 rtl/fu_issue_fifo.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fu_issue_fifo.sv
// -----------------------------------------------------------------------------
// fu_issue_fifo
// Multi-push / multi-pop circular issue buffer sitting between IN_W issue
// lanes and OUT_W functional-unit read ports.
//
// Ports
//   clock         sole clock, rising edge
//   reset         asynchronous, active-low; clears all state
//   pkt_in        IN_W packets, lane i at [i*PKT_W +: PKT_W], lane 0 oldest
//   in_valid      per-lane push request
//   rd_en         per-port FU ready
//   flush         squash all contents; blocks pops and ignores pushes
//   pkt_out       OUT_W packets, port j at [j*PKT_W +: PKT_W]
//   out_valid     port j carries a valid issue this cycle
//   count         current occupancy
//   empty/full    count == 0 / count == DEPTH
//   almost_full   count > DEPTH - IN_W (upstream stall)
//   overflow_err  sticky, set whenever a push is dropped for lack of space
// -----------------------------------------------------------------------------
module fu_issue_fifo #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 3,
    parameter int DEPTH = 8,
    parameter int PKT_W = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [IN_W*PKT_W-1:0]         pkt_in,
    input  logic [IN_W-1:0]               in_valid,
    input  logic [OUT_W-1:0]              rd_en,
    input  logic                          flush,
    output logic [OUT_W*PKT_W-1:0]        pkt_out,
    output logic [OUT_W-1:0]              out_valid,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_full,
    output logic                          overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PKT_W-1:0]         mem_r [DEPTH];
    logic [PW-1:0]            head_r;
    logic [PW-1:0]            tail_r;
    logic [CW-1:0]            count_r;
    logic                     overflow_r;

    logic [CW-1:0]            pops_s;
    logic [CW-1:0]            space_s;
    logic [CW-1:0]            accepted_s;
    logic                     drop_s;
    logic [OUT_W-1:0]         out_valid_s;
    logic [OUT_W*PKT_W-1:0]   pkt_out_s;
    logic [IN_W-1:0]          wr_en_s;
    logic [PW-1:0]            wr_addr_s [IN_W];

    // Read-port mapping: k-th oldest entry goes to the k-th ready port.
    always_comb begin : map_p
        logic [CW-1:0] k_v;
        logic [PW-1:0] rd_idx_v;
        k_v         = {CW{1'b0}};
        rd_idx_v    = {PW{1'b0}};
        out_valid_s = {OUT_W{1'b0}};
        pkt_out_s   = {(OUT_W*PKT_W){1'b0}};
        for (int j = 0; j < OUT_W; j++) begin
            rd_idx_v = head_r + k_v[PW-1:0];
            if (!flush && rd_en[j] && (k_v < count_r)) begin
                out_valid_s[j]                = 1'b1;
                pkt_out_s[j*PKT_W +: PKT_W]   = mem_r[rd_idx_v];
                k_v                           = k_v + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                out_valid_s[j]                = 1'b0;
            end
        end
        pops_s = k_v;
    end

    // Space includes slots freed by this cycle's pops (pops read pre-edge data).
    assign space_s = CW'(DEPTH) - count_r + pops_s;

    // Push compaction: valid lanes fill tail, tail+1, ... in lane order;
    // lanes past the available space are dropped, so the highest lanes lose.
    always_comb begin : push_p
        logic [CW-1:0] acc_v;
        acc_v  = {CW{1'b0}};
        drop_s = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            wr_en_s[i]   = 1'b0;
            wr_addr_s[i] = tail_r + acc_v[PW-1:0];
            if (in_valid[i] && !flush) begin
                if (acc_v < space_s) begin
                    wr_en_s[i] = 1'b1;
                    acc_v      = acc_v + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    drop_s     = 1'b1;
                end
            end else begin
                wr_en_s[i]   = 1'b0;
            end
        end
        accepted_s = acc_v;
    end

    // Entry storage: compacted lanes written at their tail-relative slots.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < DEPTH; d++) begin
                mem_r[d] <= {PKT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < IN_W; i++) begin
                if (wr_en_s[i]) begin
                    mem_r[wr_addr_s[i]] <= pkt_in[i*PKT_W +: PKT_W];
                end
            end
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else if (flush) begin
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
        end else begin
            head_r     <= head_r + pops_s[PW-1:0];
            tail_r     <= tail_r + accepted_s[PW-1:0];
            count_r    <= count_r - pops_s + accepted_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign pkt_out      = pkt_out_s;
    assign out_valid    = out_valid_s;
    assign count        = count_r;
    assign empty        = (count_r == {CW{1'b0}});
    assign full         = (count_r == CW'(DEPTH));
    assign almost_full  = (count_r > CW'(DEPTH - IN_W));
    assign overflow_err = overflow_r;

endmodule
